// File: rtl/onehot_line_counter_pkg.sv
// Shared constants and state encoding for the one-hot line counter.
package onehot_pkg;
  localparam int NUM_LINES = 8;
  localparam int IDX_W     = 3;

  typedef enum logic [0:0] {
    RUN = 1'b0,
    CLR = 1'b1
  } state_e;
endpackage

// File: rtl/onehot_line_counter_if.sv
// Bundle of data, readout and status signals between the decoder-side master and the counter block.
interface onehot_line_counter_if #(
  parameter int CNT_W = 16
);
  logic                              in_valid;
  logic [onehot_pkg::NUM_LINES-1:0]  in_onehot;
  logic                              clear;
  logic                              busy;
  logic                              rd_req;
  logic [onehot_pkg::IDX_W-1:0]      rd_idx;
  logic                              rd_valid;
  logic [CNT_W-1:0]                  rd_data;
  logic [onehot_pkg::NUM_LINES-1:0]  sat;
  logic                              err_zero;
  logic                              err_multi;

  modport master (
    output in_valid, in_onehot, clear, rd_req, rd_idx,
    input  busy, rd_valid, rd_data, sat, err_zero, err_multi
  );

  modport slave (
    input  in_valid, in_onehot, clear, rd_req, rd_idx,
    output busy, rd_valid, rd_data, sat, err_zero, err_multi
  );
endinterface

// File: rtl/onehot_line_counter_enc.sv
// Combinational one-hot classifier: line index of the set bit plus zero / multi-hot indications.
module onehot_encoder
  import onehot_pkg::*;
(
  input  logic [NUM_LINES-1:0] i_word,
  output logic [IDX_W-1:0]     o_idx,
  output logic                 o_is_zero,
  output logic                 o_is_multi
);

  logic [IDX_W-1:0] w_idx;

  // OR of indices is exact for a one-hot word; the value is unused otherwise.
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (i_word[i]) w_idx = w_idx | IDX_W'(i);
    end
  end

  assign o_idx      = w_idx;
  assign o_is_zero  = ~|i_word;
  assign o_is_multi = |(i_word & (i_word - NUM_LINES'(1)));

endmodule

// File: rtl/onehot_line_counter.sv
// Per-line saturating hit counters fed by a one-hot word, with sticky error flags,
// registered readout and an 8-cycle sequenced clear sweep.
module onehot_line_counter
  import onehot_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  onehot_line_counter_if.slave    bus
);

  localparam logic [0:0]       S_RUN   = RUN;
  localparam logic [0:0]       S_CLR   = CLR;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [IDX_W-1:0] PTR_END = IDX_W'(NUM_LINES - 1);

  logic [0:0]           r_state;
  logic [IDX_W-1:0]     r_ptr;
  logic                 r_busy;
  logic [CNT_W-1:0]     r_cnt [NUM_LINES];
  logic [NUM_LINES-1:0] r_sat;
  logic                 r_err_zero;
  logic                 r_err_multi;
  logic                 r_rd_valid;
  logic [CNT_W-1:0]     r_rd_data;

  logic [IDX_W-1:0]     w_idx;
  logic                 w_is_zero;
  logic                 w_is_multi;

  onehot_encoder u_enc (
    .i_word     (bus.in_onehot),
    .o_idx      (w_idx),
    .o_is_zero  (w_is_zero),
    .o_is_multi (w_is_multi)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_RUN;
      r_ptr       <= '0;
      r_busy      <= 1'b0;
      r_sat       <= '0;
      r_err_zero  <= 1'b0;
      r_err_multi <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
      for (int i = 0; i < NUM_LINES; i++) r_cnt[i] <= '0;
    end else begin
      // Readout samples the counter before any update on this edge.
      r_rd_valid <= bus.rd_req;
      if (bus.rd_req) r_rd_data <= r_cnt[bus.rd_idx];

      case (r_state)
        S_RUN: begin
          if (bus.clear) begin
            r_state     <= S_CLR;
            r_busy      <= 1'b1;
            r_ptr       <= '0;
            r_err_zero  <= 1'b0;
            r_err_multi <= 1'b0;
          end else if (bus.in_valid) begin
            if (w_is_zero) begin
              r_err_zero <= 1'b1;
            end else if (w_is_multi) begin
              r_err_multi <= 1'b1;
            end else if (r_cnt[w_idx] == CNT_MAX) begin
              r_sat[w_idx] <= 1'b1;
            end else begin
              r_cnt[w_idx] <= r_cnt[w_idx] + CNT_W'(1);
            end
          end
        end
        S_CLR: begin
          r_cnt[r_ptr] <= '0;
          r_sat[r_ptr] <= 1'b0;
          r_ptr        <= r_ptr + IDX_W'(1);
          if (r_ptr == PTR_END) begin
            r_state <= S_RUN;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_RUN;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.rd_data   = r_rd_data;
  assign bus.sat       = r_sat;
  assign bus.err_zero  = r_err_zero;
  assign bus.err_multi = r_err_multi;

endmodule
